// File: rtl/all_pkgs.sv
// Shared types and constants for the data-memory responder slice.
package all_pkgs;
  localparam int WIDTH = 32;
  localparam int BE_W  = WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmr_state_t;
endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with byte-enable synchronous write and combinational read.
module dmem_array
  import all_pkgs::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [BE_W-1:0]  be,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; contents survive rst and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency load/store responder over valid/ready; holds each response until accepted.
module data_mem_responder
  import all_pkgs::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr_en,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [BE_W-1:0]  req_be,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  dmr_state_t       state;
  logic [3:0]       cnt;
  logic             lat_wr_en;
  logic [WIDTH-1:0] lat_addr;
  logic [WIDTH-1:0] lat_wdata;
  logic [BE_W-1:0]  lat_be;

  logic             commit;
  logic             c_wr_en;
  logic [WIDTH-1:0] c_addr;
  logic [WIDTH-1:0] c_wdata;
  logic [BE_W-1:0]  c_be;
  logic [WIDTH-1:0] word_idx;
  logic             c_err;
  logic [WIDTH-1:0] mem_rdata;

  // With LATENCY=1 the commit happens on the accept edge, before the latches hold the request.
  assign c_wr_en = (state == IDLE) ? req_wr_en : lat_wr_en;
  assign c_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign c_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign c_be    = (state == IDLE) ? req_be    : lat_be;

  assign commit   = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
                    ((state == WAIT) && (cnt == 4'd0));
  assign word_idx = {2'b00, c_addr[WIDTH-1:2]};
  assign c_err    = (c_addr[1:0] != 2'b00) || (word_idx >= WIDTH'(DEPTH));

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (commit && c_wr_en && !c_err && !rst),
    .be    (c_be),
    .waddr (word_idx[AW-1:0]),
    .wdata (c_wdata),
    .raddr (word_idx[AW-1:0]),
    .rdata (mem_rdata)
  );

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (commit) begin
        state     <= RESP;
        rsp_valid <= 1'b1;
        rsp_err   <= c_err;
        rsp_rdata <= (!c_err && !c_wr_en) ? mem_rdata : '0;
      end

      unique case (state)
        IDLE: begin
          if (req_valid) begin
            lat_wr_en <= req_wr_en;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            req_ready <= 1'b0;
            if (LATENCY != 1) begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder at LATENCY 2, 4 and 1 (one instance each).
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  logic        clk = 1'b0;
  logic        rst       [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_wr_en [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int          lat [3] = '{2, 4, 1};
  logic [31:0] model [3][256];
  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wr_en(req_wr_en[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_be(req_be[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  data_mem_responder #(.DEPTH(256), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wr_en(req_wr_en[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_be(req_be[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  data_mem_responder #(.DEPTH(256), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wr_en(req_wr_en[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_be(req_be[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Model of one accepted request: computes the response and updates the reference memory.
  task automatic push_expect(input int d, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
    exp_t        e;
    logic [31:0] idx;
    idx     = addr >> 2;
    e.err   = (addr[1:0] != 2'b00) || (idx >= 32'd256);
    e.rdata = 32'h0;
    if (!e.err) begin
      if (wr) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) model[d][idx[7:0]][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        e.rdata = model[d][idx[7:0]];
      end
    end
    sb.push_back(e);
  endtask

  task automatic check_idle(input int d, input string tag);
    check({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata[d], 32'h0);
    check({tag, "_rsp_err"},   32'(rsp_err[d]),   32'd0);
  endtask

  // One transaction; hold>0 keeps rsp_ready low for that many cycles and pokes a request meanwhile.
  task automatic do_txn(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int hold);
    exp_t        e;
    int          n;
    logic [31:0] held;
    @(negedge clk);
    req_wr_en[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    req_valid[d] = 1'b1;
    rsp_ready[d] = (hold == 0);
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 20), 32'd1);
    push_expect(d, wr, addr, wdata, be);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_wr_en[d] = 1'($urandom);
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    req_be[d]    = 4'($urandom);
    n = 1;
    while (!rsp_valid[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rsp_latency", 32'(n), 32'(lat[d]));
    e = sb.pop_front();
    check("rsp_rdata", rsp_rdata[d], e.rdata);
    check("rsp_err",   32'(rsp_err[d]), 32'(e.err));
    held = rsp_rdata[d];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid[d]), 32'd1);
      check("bp_rsp_rdata", rsp_rdata[d], held);
      check("bp_req_ready", 32'(req_ready[d]), 32'd0);
      if (k == 1) begin
        req_valid[d] = 1'b1;
        req_wr_en[d] = 1'b1;
        req_addr[d]  = 32'h0;
        req_wdata[d] = 32'h0BAD0BAD;
        req_be[d]    = 4'hF;
      end else begin
        req_valid[d] = 1'b0;
      end
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    check_idle(d, "after_hs");
  endtask

  initial begin
    req_t        b2b [4];
    exp_t        e;
    int          n;
    int          prev;

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      req_valid[d] = 1'b0;
      req_wr_en[d] = 1'b0;
      req_addr[d]  = 32'h0;
      req_wdata[d] = 32'h0;
      req_be[d]    = 4'h0;
      rsp_ready[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_idle(d, "reset");
      rst[d] = 1'b0;
    end

    // LATENCY=2: basic store/load, partial store, errors, be=0 no-op, backpressure
    do_txn(0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 0);
    do_txn(0, 1'b0, 32'h10,  32'h0,        4'h0, 0);
    do_txn(0, 1'b1, 32'h14,  32'h11223344, 4'hF, 0);
    do_txn(0, 1'b1, 32'h14,  32'h0000AA00, 4'b0010, 0);
    do_txn(0, 1'b0, 32'h14,  32'h0,        4'h0, 0);
    do_txn(0, 1'b0, 32'h13,  32'h0,        4'h0, 0);
    do_txn(0, 1'b1, 32'h0,   32'hA5A5A5A5, 4'hF, 0);
    do_txn(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0);
    do_txn(0, 1'b0, 32'h0,   32'h0,        4'h0, 0);
    do_txn(0, 1'b1, 32'h10,  32'h12345678, 4'h0, 0);
    do_txn(0, 1'b0, 32'h10,  32'h0,        4'h0, 5);
    do_txn(0, 1'b0, 32'h0,   32'h0,        4'h0, 0);

    // LATENCY=4: reset while a store to 0x20 is in WAIT
    do_txn(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0);
    @(negedge clk);
    req_wr_en[1] = 1'b1;
    req_addr[1]  = 32'h20;
    req_wdata[1] = 32'h12345678;
    req_be[1]    = 4'hF;
    req_valid[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    check("rst_pre_accept_ready", 32'(req_ready[1]), 32'd1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("rst_in_wait_ready", 32'(req_ready[1]), 32'd0);
    rst[1] = 1'b1;
    @(negedge clk);
    check_idle(1, "rst_in_wait");
    rst[1] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rst_no_rsp", 32'(rsp_valid[1]), 32'd0);
    end
    do_txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 0);

    // LATENCY=1: back-to-back with req_valid and rsp_ready held high
    b2b[0] = '{1'b1, 32'h40, 32'hAAAA0001, 4'hF};
    b2b[1] = '{1'b1, 32'h44, 32'hBBBB0002, 4'hF};
    b2b[2] = '{1'b0, 32'h40, 32'h0,        4'h0};
    b2b[3] = '{1'b0, 32'h44, 32'h0,        4'h0};
    rsp_ready[2] = 1'b1;
    prev = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req_wr_en[2] = b2b[i].wr;
      req_addr[2]  = b2b[i].addr;
      req_wdata[2] = b2b[i].wdata;
      req_be[2]    = b2b[i].be;
      req_valid[2] = 1'b1;
      n = 0;
      while (!req_ready[2] && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("b2b_accept_timeout", 32'(n < 20), 32'd1);
      if (i > 0) begin
        check("b2b_spacing",      32'(cyc - prev), 32'd2);
        check("b2b_rsp_one_cyc",  32'(rsp_valid[2]), 32'd0);
      end
      push_expect(2, b2b[i].wr, b2b[i].addr, b2b[i].wdata, b2b[i].be);
      prev = cyc;
      @(negedge clk);
      check("b2b_rsp_valid", 32'(rsp_valid[2]), 32'd1);
      e = sb.pop_front();
      check("b2b_rsp_rdata", rsp_rdata[2], e.rdata);
      check("b2b_rsp_err",   32'(rsp_err[2]), 32'(e.err));
    end
    req_valid[2] = 1'b0;
    @(negedge clk);
    check_idle(2, "b2b_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
